cosim_trace_tx: RTL

//  DUT-side transmitter of the co-simulation commit protocol. Samples per-cycle retire events from the Rocket

---
 rtl/cosim_trace_tx.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/cosim_trace_tx.sv
// Difftest commit-trace transmitter: buffers per-cycle retire events as bundles
// and serialises each event as a typed 128-bit record on a valid/ready stream.
module cosim_trace_tx #(
  parameter int DEPTH     = 8,
  parameter int HARTID    = 0,
  parameter int AFULL_GAP = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         commit_valid,
  input  logic [63:0]  commit_pc,
  input  logic [31:0]  commit_insn,
  input  logic         int_wen,
  input  logic         int_ll_wen,
  input  logic [4:0]   int_waddr,
  input  logic [63:0]  int_wdata,
  input  logic         fp_wen,
  input  logic [4:0]   fp_waddr,
  input  logic [63:0]  fp_wdata,
  input  logic         fpld_wen,
  input  logic [4:0]   fpld_waddr,
  input  logic [63:0]  fpld_wdata,
  input  logic         trap_valid,
  input  logic [63:0]  trap_cause,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         stall_req,
  output logic         overflow,
  output logic [15:0]  drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] GAP_C   = CW'(AFULL_GAP);
  localparam logic [7:0]    HID     = 8'(HARTID);

  typedef struct packed {
    logic [5:0]  mask;
    logic [63:0] pc;
    logic [31:0] insn;
    logic [4:0]  iaddr;
    logic [63:0] idata;
    logic [4:0]  faddr;
    logic [63:0] fdata;
    logic [4:0]  laddr;
    logic [63:0] ldata;
    logic [63:0] cause;
  } bundle_t;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  bundle_t       r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [5:0]    r_done;
  logic [15:0]   r_seq;
  logic          r_stall, r_overflow;
  logic [15:0]   r_drop;
  state_t        r_state, w_state_nxt;

  bundle_t       w_in, w_head;
  logic [5:0]    w_pend, w_bit;
  logic [2:0]    w_type;
  logic          w_last, w_fire, w_pop, w_push_req, w_full, w_push, w_drop;
  logic [CW-1:0] w_count_nxt, w_free_nxt;
  logic [4:0]    w_idx;
  logic [63:0]   w_payload;
  logic [31:0]   w_low;

  function automatic logic [127:0] make_record(input logic [2:0] typ, input logic [15:0] seq,
                                               input logic [31:0] low, input logic [63:0] payload);
    return {payload, typ, 13'd0, seq, low};
  endfunction

  // Bundle capture from the core's retire ports
  always_comb begin
    w_in.mask  = {trap_valid, fpld_wen, fp_wen, int_ll_wen, int_wen, commit_valid};
    w_in.pc    = commit_pc;
    w_in.insn  = commit_insn;
    w_in.iaddr = int_waddr;
    w_in.idata = int_wdata;
    w_in.faddr = fp_waddr;
    w_in.fdata = fp_wdata;
    w_in.laddr = fpld_waddr;
    w_in.ldata = fpld_wdata;
    w_in.cause = trap_cause;
  end

  // The FIFO head is emitted in place, so an event reaches the stream the cycle after capture
  always_comb begin
    w_head = r_mem[r_rptr];
    w_pend = w_head.mask & ~r_done;
    w_type = 3'd0;
    casez (w_pend)
      6'b?????1: w_type = 3'd0;
      6'b????10: w_type = 3'd1;
      6'b???100: w_type = 3'd2;
      6'b??1000: w_type = 3'd3;
      6'b?10000: w_type = 3'd4;
      6'b100000: w_type = 3'd5;
      default:   w_type = 3'd0;
    endcase
    w_bit       = 6'b000001 << w_type;
    w_last      = ((w_pend & ~w_bit) == 6'b000000);
    w_fire      = out_valid & out_ready;
    w_pop       = w_fire & w_last;
    w_push_req  = |w_in.mask;
    w_full      = (r_count == DEPTH_C);
    w_push      = w_push_req & (~w_full | w_pop);
    w_drop      = w_push_req & w_full & ~w_pop;
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    w_free_nxt  = DEPTH_C - w_count_nxt;
    w_state_nxt = IDLE;
    case (r_state)
      IDLE:    w_state_nxt = w_push ? EMIT : IDLE;
      EMIT:    w_state_nxt = (w_count_nxt == '0) ? IDLE : EMIT;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Record formatting for the currently selected event
  always_comb begin
    w_idx     = 5'd0;
    w_payload = 64'd0;
    case (w_type)
      3'd0:    begin w_idx = 5'd0;         w_payload = w_head.pc;    end
      3'd1:    begin w_idx = w_head.iaddr; w_payload = w_head.idata; end
      3'd2:    begin w_idx = w_head.iaddr; w_payload = w_head.idata; end
      3'd3:    begin w_idx = w_head.faddr; w_payload = w_head.fdata; end
      3'd4:    begin w_idx = w_head.laddr; w_payload = w_head.ldata; end
      3'd5:    begin w_idx = 5'd0;         w_payload = w_head.cause; end
      default: begin w_idx = 5'd0;         w_payload = 64'd0;        end
    endcase
    if (w_type == 3'd0) begin
      w_low = w_head.insn;
    end else begin
      w_low = {8'h00, 3'b000, w_idx, HID, 8'h00};
    end
    if (out_valid) begin
      out_data = make_record(w_type, r_seq, w_low, w_payload);
    end else begin
      out_data = 128'd0;
    end
  end

  assign out_valid  = (r_state == EMIT);
  assign stall_req  = r_stall;
  assign overflow   = r_overflow;
  assign drop_count = r_drop;

  // Bundle storage; contents are don't-care outside the valid window so no reset
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_in;
    end
  end

  // FIFO pointers, serializer state and status counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_done     <= 6'd0;
      r_seq      <= 16'd0;
      r_state    <= IDLE;
      r_stall    <= 1'b0;
      r_overflow <= 1'b0;
      r_drop     <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_stall <= (w_free_nxt <= GAP_C);
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_fire) begin
        r_seq  <= r_seq + 16'd1;
        r_done <= w_last ? 6'd0 : (r_done | w_bit);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop != 16'hFFFF) begin
          r_drop <= r_drop + 16'd1;
        end
      end
    end
  end
endmodule
